// File: rtl/inst_fetch_unit.sv
// Fetch stage: direct-mapped one-word-per-line I-cache with miss refill from memory,
// pushing {inst, pc} into the instruction queue and honouring predictor/ROB redirects.
module inst_fetch_unit #(
    parameter int unsigned INDEX_BITS = 7,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        bp_if_en_in,
    input  logic [31:0] bp_if_pc_in,
    input  logic        rob_if_en_in,
    input  logic [31:0] rob_if_pc_in,
    input  logic        iq_full_in,
    output logic        if_iq_en_out,
    output logic [31:0] if_iq_inst_out,
    output logic [31:0] if_iq_pc_out,
    output logic        if_mem_req_out,
    output logic [31:0] if_mem_addr_out,
    input  logic        mem_if_valid_in,
    input  logic [31:0] mem_if_data_in
);
    localparam int unsigned LINES    = 32'd1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [31:0]         pc_r, pc_s;
    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0]         data_mem [LINES];

    logic                iq_en_r, iq_en_s;
    logic [31:0]         iq_inst_r, iq_inst_s;
    logic [31:0]         iq_pc_r, iq_pc_s;
    logic                mem_req_r, mem_req_s;
    logic [31:0]         mem_addr_r, mem_addr_s;

    logic [INDEX_BITS-1:0] idx_s;
    logic [INDEX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  hit_s;
    logic                  redir_s;
    logic [31:0]           redir_pc_s;
    logic                  fill_s;

    assign idx_s      = pc_r[INDEX_BITS+1:2];
    assign tag_s      = pc_r[31:INDEX_BITS+2];
    assign fill_idx_s = mem_addr_r[INDEX_BITS+1:2];
    assign hit_s      = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
    assign redir_s    = rob_if_en_in || bp_if_en_in;
    assign redir_pc_s = rob_if_en_in ? rob_if_pc_in : bp_if_pc_in;

    // Next-state and registered-output values for the RUN/MISS controller.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        iq_en_s    = 1'b0;
        iq_inst_s  = iq_inst_r;
        iq_pc_s    = iq_pc_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        fill_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (redir_s) begin
                    pc_s = redir_pc_s;
                end else if (hit_s) begin
                    if (!iq_full_in) begin
                        iq_en_s   = 1'b1;
                        iq_inst_s = data_mem[idx_s];
                        iq_pc_s   = pc_r;
                        pc_s      = pc_r + 32'd4;
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    mem_req_s  = 1'b1;
                    mem_addr_s = pc_r;
                    state_s    = MISS;
                end
            end
            MISS: begin
                // The request in flight is never cancelled; a redirect only retargets pc.
                if (redir_s) begin
                    pc_s = redir_pc_s;
                end else begin
                    pc_s = pc_r;
                end
                if (mem_if_valid_in) begin
                    fill_s    = 1'b1;
                    mem_req_s = 1'b0;
                    state_s   = RUN;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            default: begin
                state_s   = RUN;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Controller state, pc, valid bits and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= RUN;
            pc_r       <= RESET_PC;
            valid_r    <= '0;
            iq_en_r    <= 1'b0;
            iq_inst_r  <= 32'h0000_0000;
            iq_pc_r    <= 32'h0000_0000;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
        end else if (rdy_in) begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            iq_en_r    <= iq_en_s;
            iq_inst_r  <= iq_inst_s;
            iq_pc_r    <= iq_pc_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Cache tag/data arrays; only the valid bits need clearing on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && fill_s) begin
            data_mem[fill_idx_s] <= mem_if_data_in;
            tag_mem[fill_idx_s]  <= mem_addr_r[31:INDEX_BITS+2];
        end
    end

    // A frozen push register must not be seen as a second push while stalled.
    assign if_iq_en_out    = iq_en_r & rdy_in;
    assign if_iq_inst_out  = iq_inst_r;
    assign if_iq_pc_out    = iq_pc_r;
    assign if_mem_req_out  = mem_req_r;
    assign if_mem_addr_out = mem_addr_r;

endmodule
